// File: rtl/p_int_mul_pow2_seq_pkg.sv
// -----------------------------------------------------------------------------
// p_int_mul_pow2_seq_pkg
// Shared types for the power-of-two multiplier / divider pair:
//   dconf_t          - number format: sign flag plus bit width
//   DEF_DCONF        - default format (signed, 8 bits)
//   mul_pow2_state_t - FSM states of the iterative multiplier
// -----------------------------------------------------------------------------
package p_int_mul_pow2_seq_pkg;

   typedef struct packed {
      logic       sign;
      logic [7:0] prec;
   } dconf_t;

   localparam dconf_t DEF_DCONF = '{sign: 1'b1, prec: 8'd8};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } mul_pow2_state_t;

endpackage

// File: rtl/p_int_mul_pow2_seq.sv
// -----------------------------------------------------------------------------
// p_int_mul_pow2_seq
// Iterative multiply-by-2^k with saturation. Rebuilds (in << shamt) | rem one
// bit per cycle, saturating to the output format when the value overflows.
//
// Ports:
//   clk       - clock, rising edge
//   reset_    - asynchronous active-low reset
//   in_valid  - request valid
//   in_ready  - block can accept a request (IDLE only)
//   in        - quotient operand (I_PREC bits)
//   rem       - remainder bits, only [shamt-1:0] are used
//   shamt     - shift amount, values above MAX_SHIFT clamp to MAX_SHIFT
//   out_valid - result valid (DONE)
//   out_ready - consumer accepts the result
//   out       - result (O_PREC bits), held while out_valid & !out_ready
//   ovf       - result was saturated
//   busy      - state is not IDLE
// -----------------------------------------------------------------------------
module p_int_mul_pow2_seq
   import p_int_mul_pow2_seq_pkg::*;
#(
   parameter int     MAX_SHIFT = 4,
   parameter dconf_t I_CONF    = DEF_DCONF,
   parameter dconf_t O_CONF    = DEF_DCONF,
   parameter int     I_PREC    = int'(I_CONF.prec),
   parameter int     O_PREC    = int'(O_CONF.prec),
   parameter int     SH_W      = $clog2(MAX_SHIFT + 1)
)(
   input  logic                 clk,
   input  logic                 reset_,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [I_PREC-1:0]    in,
   input  logic [MAX_SHIFT-1:0] rem,
   input  logic [SH_W-1:0]      shamt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [O_PREC-1:0]    out,
   output logic                 ovf,
   output logic                 busy
);

   // Saturation limits of the output format
   localparam logic [O_PREC-1:0] SAT_POS = {1'b0, {(O_PREC-1){1'b1}}};
   localparam logic [O_PREC-1:0] SAT_NEG = {1'b1, {(O_PREC-1){1'b0}}};
   localparam logic [O_PREC-1:0] SAT_U   = {O_PREC{1'b1}};
   localparam logic [SH_W-1:0]   SH_MAX  = SH_W'(MAX_SHIFT);

   mul_pow2_state_t       state;
   logic [O_PREC-1:0]     acc;
   logic [MAX_SHIFT-1:0]  rem_sr;
   logic [SH_W-1:0]       cnt;
   logic                  ovf_r;
   logic                  sign_r;

   logic [SH_W-1:0]       shamt_c;
   logic [O_PREC-1:0]     in_ext;
   logic [MAX_SHIFT-1:0]  rem_aligned;
   logic                  in_sign;
   logic [O_PREC-1:0]     acc_shift;
   logic                  ovf_next;
   logic [O_PREC-1:0]     sat_val;

   // Operand preparation at accept: clamp, extend, left-align the remainder
   always_comb begin
      shamt_c     = (shamt > SH_MAX) ? SH_MAX : shamt;
      rem_aligned = rem << (SH_MAX - shamt_c);
      if (I_CONF.sign) begin
         in_ext  = O_PREC'($signed(in));
         in_sign = in[I_PREC-1];
      end else begin
         in_ext  = O_PREC'(in);
         in_sign = 1'b0;
      end
   end

   // One shift step plus sticky overflow, judged on acc before the shift:
   // a signed value can only be doubled safely while its top two bits agree.
   always_comb begin
      acc_shift = {acc[O_PREC-2:0], rem_sr[MAX_SHIFT-1]};
      if (I_CONF.sign) begin
         ovf_next = ovf_r | (acc[O_PREC-1] ^ acc[O_PREC-2]);
         sat_val  = sign_r ? SAT_NEG : SAT_POS;
      end else begin
         ovf_next = ovf_r | acc[O_PREC-1];
         sat_val  = SAT_U;
      end
   end

   // FSM, datapath and registered handshake/result outputs
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state     <= IDLE;
         acc       <= '0;
         rem_sr    <= '0;
         cnt       <= '0;
         ovf_r     <= 1'b0;
         sign_r    <= 1'b0;
         out       <= '0;
         ovf       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // in_ready is registered high throughout IDLE
               if (in_valid) begin
                  acc      <= in_ext;
                  rem_sr   <= rem_aligned;
                  cnt      <= shamt_c;
                  ovf_r    <= 1'b0;
                  sign_r   <= in_sign;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (shamt_c == {SH_W{1'b0}}) begin
                     state     <= DONE;
                     out       <= in_ext;
                     ovf       <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               acc    <= acc_shift;
               rem_sr <= rem_sr << 1;
               cnt    <= cnt - SH_W'(1);
               ovf_r  <= ovf_next;
               // Last step: result and saturation are settled on the DONE entry edge
               if (cnt == SH_W'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  ovf       <= ovf_next;
                  out       <= ovf_next ? sat_val : acc_shift;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_p_int_mul_pow2_seq.sv
module tb_p_int_mul_pow2_seq;
   import p_int_mul_pow2_seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset_ = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_d = 8'd0;
   logic [3:0] rem = 4'd0;
   logic [2:0] shamt = 3'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out;
   logic       ovf;
   logic       busy;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   p_int_mul_pow2_seq #(
      .MAX_SHIFT(4),
      .I_CONF   (DEF_DCONF),
      .O_CONF   (DEF_DCONF)
   ) dut (
      .clk      (clk),
      .reset_   (reset_),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in       (in_d),
      .rem      (rem),
      .shamt    (shamt),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out      (out),
      .ovf      (ovf),
      .busy     (busy)
   );

   typedef struct {
      logic [7:0] a;
      logic [3:0] r;
      logic [2:0] s;
      logic [7:0] eo;
      logic       ev;
      int         el;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   // Reference: value = in * 2^k + low k remainder bits, saturated to 8-bit signed
   task automatic model(input logic [7:0] a, input logic [3:0] r, input logic [2:0] s,
                        output logic [7:0] o, output logic v, output int lat);
      int k;
      int ai;
      int val;
      k   = (s > 3'd4) ? 4 : int'(s);
      ai  = int'($signed(a));
      val = ai * (1 << k) + (int'(r) & ((1 << k) - 1));
      lat = k + 1;
      if (val > 127) begin
         o = 8'h7F; v = 1'b1;
      end else if (val < -128) begin
         o = 8'h80; v = 1'b1;
      end else begin
         o = val[7:0]; v = 1'b0;
      end
   endtask

   // Called at a negedge; returns at the negedge where out_valid is seen (or budget expiry)
   task automatic do_op(input logic [7:0] a, input logic [3:0] r, input logic [2:0] s,
                        output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      in_d = a; rem = r; shamt = s; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int el;
      logic [7:0] eo;
      logic ev;
      logic [7:0] held_o;
      logic held_v;
      int seen;

      vecs[0] = '{8'h03, 4'b0001, 3'd2, 8'h0D, 1'b0, 3};
      vecs[1] = '{8'hFD, 4'b0011, 3'd2, 8'hF7, 1'b0, 3};
      vecs[2] = '{8'h28, 4'b0000, 3'd2, 8'h7F, 1'b1, 3};
      vecs[3] = '{8'hD8, 4'b0000, 3'd2, 8'h80, 1'b1, 3};
      vecs[4] = '{8'h5A, 4'b0000, 3'd0, 8'h5A, 1'b0, 1};
      vecs[5] = '{8'h01, 4'b0000, 3'd7, 8'h10, 1'b0, 5};
      vecs[6] = '{8'h07, 4'b1111, 3'd4, 8'h7F, 1'b0, 5};
      vecs[7] = '{8'h08, 4'b0000, 3'd4, 8'h7F, 1'b1, 5};
      vecs[8] = '{8'hF8, 4'b0000, 3'd4, 8'h80, 1'b0, 5};

      // Reset values
      #2 reset_ = 1'b0;
      #10;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out", int'(out), 0);
      check("rst_ovf", int'(ovf), 0);
      check("rst_busy", int'(busy), 0);
      @(negedge clk);
      reset_ = 1'b1;
      @(negedge clk);

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].a, vecs[i].r, vecs[i].s, lat);
         check($sformatf("vec%0d_out", i), int'(out), int'(vecs[i].eo));
         check($sformatf("vec%0d_ovf", i), int'(ovf), int'(vecs[i].ev));
         check($sformatf("vec%0d_lat", i), lat, vecs[i].el);
      end

      // Output hold with out_ready low, pending request must not be accepted
      @(negedge clk);
      out_ready = 1'b0;
      do_op(8'h28, 4'b0000, 3'd2, lat);
      check("hold_first_out", int'(out), 8'h7F);
      in_d = 8'h03; rem = 4'b0001; shamt = 3'd1; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("hold_out", int'(out), 8'h7F);
         check("hold_ovf", int'(ovf), 1);
         check("hold_in_ready", int'(in_ready), 0);
         check("hold_out_valid", int'(out_valid), 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", int'(in_ready), 1);
      check("release_out_valid", int'(out_valid), 0);
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_busy", int'(busy), 1);
      check("b2b_in_ready", int'(in_ready), 0);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_lat", lat, 2);
      check("b2b_out", int'(out), 7);
      check("b2b_ovf", int'(ovf), 0);

      // Reset in the middle of SHIFT
      @(negedge clk);
      @(negedge clk);
      in_d = 8'h01; rem = 4'b0000; shamt = 3'd4; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1 reset_ = 1'b0;
      #1;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      reset_ = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midrst_no_stale", seen, 0);
      do_op(8'hFD, 4'b0011, 3'd2, lat);
      check("postrst_out", int'(out), 8'hF7);
      check("postrst_lat", lat, 3);

      // Randomized operations against the arithmetic model
      for (int i = 0; i < 150; i++) begin
         logic [7:0] a;
         logic [3:0] r;
         logic [2:0] s;
         logic stall;
         a = 8'($urandom);
         r = 4'($urandom);
         s = 3'($urandom_range(0, 7));
         stall = ($urandom_range(0, 3) == 0);
         model(a, r, s, eo, ev, el);
         @(negedge clk);
         out_ready = !stall;
         do_op(a, r, s, lat);
         check("rnd_out", int'(out), int'(eo));
         check("rnd_ovf", int'(ovf), int'(ev));
         check("rnd_lat", lat, el);
         if (stall) begin
            held_o = out;
            held_v = ovf;
            @(negedge clk);
            @(negedge clk);
            check("rnd_stall_out", int'(out), int'(eo));
            check("rnd_stall_ovf", int'(ovf), int'(held_v));
            check("rnd_stall_valid", int'(out_valid), 1);
            if (held_o != eo) check("rnd_stall_first", int'(held_o), int'(eo));
            out_ready = 1'b1;
         end
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/p_int_mul_pow2_seq.md
# p_int_mul_pow2_seq

Iterative multiply-by-2^k with saturation: the inverse of the team's power-of-two integer divider. Takes a quotient, its remainder bits and a run-time shift amount, and rebuilds `(in << shamt) | rem` one bit per cycle. The result saturates to the output format on overflow. Sits on the perceptron datapath wherever scaled weights or activations are restored to full precision, behind a valid/ready handshake.

## Interface
- `MAX_SHIFT`, 4: largest supported shift; also the remainder width.
- `I_CONF`, `` `DEF_DCONF ``: input format (dconf_t); `.sign` selects signed/unsigned for both ports.
- `O_CONF`, `` `DEF_DCONF ``: output format. Constraint: `O_PREC >= I_PREC`.
- `I_PREC`, `I_CONF.prec`: input width.
- `O_PREC`, `O_CONF.prec`: output width.
- `SH_W`, `$clog2(MAX_SHIFT+1)`: shift-amount width.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset_` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request.
- `in` in I_PREC: quotient operand.
- `rem` in MAX_SHIFT: remainder; only bits `[shamt-1:0]` are used.
- `shamt` in SH_W: shift amount; values above MAX_SHIFT clamp to MAX_SHIFT.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out` out O_PREC: result.
- `ovf` out 1: the result was saturated.
- `busy` out 1: state is not IDLE.

## Operation
- **States**
  - IDLE: `in_ready`=1.
  - SHIFT: one bit per cycle.
  - DONE: `out_valid`=1.
- **Transitions**
  - IDLE→SHIFT on accept (`in_valid & in_ready`) when the clamped shamt is >0.
  - IDLE→DONE on accept when shamt=0.
  - SHIFT→DONE when the step counter reaches 0.
  - DONE→IDLE on `out_valid & out_ready`.
- **On accept**
  - `acc` ← `in` extended to O_PREC: sign-extended if `I_CONF.sign`, otherwise zero-extended.
  - `rem_sr` ← `rem << (MAX_SHIFT - shamt)`, i.e. left-aligned.
  - `cnt` ← shamt.
  - `ovf_r` ← 0.
  - `sign_r` ← `I_CONF.sign ? in[I_PREC-1] : 0`.
- **Each SHIFT cycle**
  - `acc` ← `{acc[O_PREC-2:0], rem_sr[MAX_SHIFT-1]}`.
  - `rem_sr` ← `rem_sr << 1`.
  - `cnt` ← `cnt - 1`.
  - Overflow detect, sticky: signed sets `ovf_r` when `acc[O_PREC-1] != acc[O_PREC-2]` before the shift; unsigned sets it when `acc[O_PREC-1]` = 1 before the shift.
- **Saturation on entering DONE**
  - If `ovf_r`: signed saturates to `{0,1…1}` when `sign_r`=0, or `{1,0…0}` when `sign_r`=1; unsigned saturates to all ones.
  - Otherwise `out` = `acc`.
- **Output holding:** `out` and `ovf` are registered, held stable while `out_valid`=1 and `out_ready`=0. They keep their last value in IDLE and are don't-care.
- **No overlap:** `in_ready`=0 in SHIFT and DONE. A request arriving then is not accepted and must be held by the source.

## Timing
- **Reset values:**
  - `in_ready`=1, `out_valid`=0, `out`=0, `ovf`=0, `busy`=0.
  - State IDLE.
- **Latency:** `out_valid` rises `shamt+1` edges after the accept edge, so 1 for shamt=0 and MAX_SHIFT+1 maximum.
- **Throughput:** one result per `shamt+2` cycles with `out_ready` held high. The DONE→IDLE edge costs one cycle.
- **Reset mid-operation:** `reset_` low at any time forces IDLE immediately and asynchronously. `out_valid` drops to 0 and the in-flight operation is discarded with no result.
- **Simultaneous events:** `in_valid` during DONE with `out_ready`=1 is not accepted that cycle; it is accepted in IDLE on the next cycle.

## Structure
- `dconf_t` and `` `DEF_DCONF `` come from perceptron.svh.
- Add the state typedef `mul_pow2_state_t` (IDLE, SHIFT, DONE) to perceptron.svh, so the companion divider wrapper and the testbench share it.
- Saturation constants are local parameters derived from O_PREC.
- No sub-module: the FSM, shifter and saturation fit in one module.

## Test plan
Configuration: I_PREC=O_PREC=8, signed, MAX_SHIFT=4.

- `in`=3, `rem`=4'b0001, `shamt`=2 → `out`=13 (0x0D), `ovf`=0, `out_valid` exactly 3 edges after accept.
- `in`=-3 (0xFD), `rem`=4'b0011, `shamt`=2 → `out`=0xF7 (-9), `ovf`=0.
- `in`=40, `shamt`=2 → `out`=0x7F, `ovf`=1. `in`=-40, `shamt`=2 → `out`=0x80, `ovf`=1.
- `shamt`=0, `in`=0x5A → `out`=0x5A one edge after accept. `shamt`=7 clamps to 4: `in`=1, `rem`=0 → `out`=16.
- `out_ready` held 0 for 5 cycles in DONE → `out`/`ovf` stable, `in_ready`=0. Release → IDLE next cycle, then back-to-back accept.
- `reset_` pulsed low during SHIFT → `out_valid`=0, `busy`=0, `in_ready`=1. No stale result is ever presented.
